// File: rtl/gpio_checkpoint_monitor.sv
// Checkpoint monitor for a firmware-driven GPIO status field: synchronizes and
// debounces the field, then sequences START/PASS/FAIL codes into a sticky verdict.
module gpio_checkpoint_monitor #(
  parameter int unsigned      WIDTH          = 16,
  parameter logic [WIDTH-1:0] START_CODE     = 16'hA000,
  parameter logic [WIDTH-1:0] PASS_CODE      = 16'hAB00,
  parameter logic [WIDTH-1:0] FAIL_CODE      = 16'hAEEE,
  parameter int unsigned      STABLE_CYCLES  = 4,
  parameter int unsigned      TIMEOUT_CYCLES = 700000,
  parameter int unsigned      CNT_W          = 20,
  parameter int unsigned      PROG_W         = 8
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic [WIDTH-1:0]  status_i,
  input  logic              clr_i,
  output logic [2:0]        state_o,
  output logic              done_o,
  output logic              pass_o,
  output logic [1:0]        fail_reason_o,
  output logic [PROG_W-1:0] progress_count_o,
  output logic [WIDTH-1:0]  last_code_o,
  output logic              event_o,
  output logic [CNT_W-1:0]  elapsed_o
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUNNING = 3'd1,
    ST_PASSED  = 3'd2,
    ST_FAILED  = 3'd3,
    ST_TIMEOUT = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    RSN_NONE      = 2'd0,
    RSN_FAIL_CODE = 2'd1,
    RSN_ORDER     = 2'd2,
    RSN_TIMEOUT   = 2'd3
  } reason_e;

  localparam int unsigned      SC_W         = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [SC_W-1:0]  STABLE_MAX   = SC_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [WIDTH-1:0]  sync1_q, sync2_q, last_acc_q;
  logic [SC_W-1:0]   stable_q, stable_d;
  state_e            state_q, state_d;
  reason_e           reason_q, reason_d;
  logic [PROG_W-1:0] prog_q, prog_d;
  logic [CNT_W-1:0]  elapsed_q, elapsed_d;
  logic              event_q, done_q, pass_q;
  logic              active, accept;

  assign active = (state_q == ST_IDLE) || (state_q == ST_RUNNING);
  // stable_q counts how many consecutive loads of sync2 matched the value before it.
  assign accept = (stable_q == STABLE_MAX) && (sync2_q != last_acc_q);

  always_comb begin
    // NOTE: every _d gets a default first, so no path can leave one unassigned (no latches).
    stable_d  = stable_q;
    state_d   = state_q;
    reason_d  = reason_q;
    prog_d    = prog_q;

    if (sync1_q != sync2_q)        stable_d = '0;
    else if (stable_q != STABLE_MAX) stable_d = stable_q + 1'b1;

    if (accept && active) begin
      if (sync2_q == FAIL_CODE) begin
        state_d  = ST_FAILED;
        reason_d = RSN_FAIL_CODE;
      end else if (sync2_q == PASS_CODE) begin
        state_d  = (state_q == ST_IDLE) ? ST_FAILED : ST_PASSED;
        reason_d = (state_q == ST_IDLE) ? RSN_ORDER : RSN_NONE;
      end else if (sync2_q == START_CODE) begin
        state_d  = (state_q == ST_IDLE) ? ST_RUNNING : ST_FAILED;
        reason_d = (state_q == ST_IDLE) ? RSN_NONE : RSN_ORDER;
      end else if (state_q == ST_RUNNING && prog_q != '1) begin
        prog_d = prog_q + 1'b1;
      end
    end

    // A transition caused by an acceptance in the same cycle beats the timeout.
    if (active && state_d == state_q && elapsed_q == TIMEOUT_LAST) begin
      state_d  = ST_TIMEOUT;
      reason_d = RSN_TIMEOUT;
    end

    elapsed_d = (state_d == ST_IDLE || state_d == ST_RUNNING) ? elapsed_q + 1'b1 : elapsed_q;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || clr_i) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      stable_q   <= '0;
      last_acc_q <= '0;
      state_q    <= ST_IDLE;
      reason_q   <= RSN_NONE;
      prog_q     <= '0;
      elapsed_q  <= '0;
      event_q    <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      sync1_q   <= status_i;
      sync2_q   <= sync1_q;
      stable_q  <= stable_d;
      state_q   <= state_d;
      reason_q  <= reason_d;
      prog_q    <= prog_d;
      elapsed_q <= elapsed_d;
      event_q   <= accept;
      if (accept) last_acc_q <= sync2_q;
      done_q    <= (state_d == ST_PASSED) || (state_d == ST_FAILED) || (state_d == ST_TIMEOUT);
      pass_q    <= (state_d == ST_PASSED);
    end
  end

  assign state_o          = state_q;
  assign done_o           = done_q;
  assign pass_o           = pass_q;
  assign fail_reason_o    = reason_q;
  assign progress_count_o = prog_q;
  assign last_code_o      = last_acc_q;
  assign event_o          = event_q;
  assign elapsed_o        = elapsed_q;

endmodule

// File: tb/tb_gpio_checkpoint_monitor.sv
// Scoreboard bench for gpio_checkpoint_monitor: a cycle-indexed reference model
// predicts every output vector; a separate monitor pops and compares after each edge.
module tb_gpio_checkpoint_monitor;

  localparam int S  = 4;
  localparam int TO = 50;
  localparam int PW = 2;
  localparam logic [15:0] C_START = 16'hA000;
  localparam logic [15:0] C_PASS  = 16'hAB00;
  localparam logic [15:0] C_FAIL  = 16'hAEEE;
  localparam int M_IDLE = 0, M_RUN = 1, M_PASSED = 2, M_FAILED = 3, M_TIMEOUT = 4;

  typedef struct packed {
    logic [2:0]    state;
    logic [1:0]    reason;
    logic [PW-1:0] prog;
    logic [15:0]   code;
    logic          ev;
    logic [19:0]   elapsed;
    logic          done;
    logic          pass;
  } obs_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clr = 1'b0;
  logic [15:0]   status = 16'h0;
  logic [2:0]    state_o;
  logic          done_o, pass_o, event_o;
  logic [1:0]    fail_reason_o;
  logic [PW-1:0] progress_count_o;
  logic [15:0]   last_code_o;
  logic [19:0]   elapsed_o;
  obs_t          dut_obs;

  always #5 clk = ~clk;

  gpio_checkpoint_monitor #(
    .WIDTH(16), .START_CODE(C_START), .PASS_CODE(C_PASS), .FAIL_CODE(C_FAIL),
    .STABLE_CYCLES(S), .TIMEOUT_CYCLES(TO), .CNT_W(20), .PROG_W(PW)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .status_i(status), .clr_i(clr),
    .state_o(state_o), .done_o(done_o), .pass_o(pass_o),
    .fail_reason_o(fail_reason_o), .progress_count_o(progress_count_o),
    .last_code_o(last_code_o), .event_o(event_o), .elapsed_o(elapsed_o)
  );

  assign dut_obs = {state_o, fail_reason_o, progress_count_o, last_code_o,
                    event_o, elapsed_o, done_o, pass_o};

  int   n_cmp = 0;
  int   n_fail = 0;
  int   ev_seen = 0;
  obs_t exp_q[$];

  // Reference model: time is counted in edges since the last reset/clear.
  int          m_e;
  logic [15:0] m_hist[$];
  logic [15:0] m_last;
  int          m_state, m_reason, m_prog, m_elapsed;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Value the pads presented before edge k; the synchronizer holds zeros before edge 1.
  function automatic logic [15:0] sample(input int k);
    if (k < 1) return 16'h0;
    return m_hist[k-1];
  endfunction

  task automatic model_step(input bit reset, input logic [15:0] v);
    obs_t        x;
    logic [15:0] cand;
    bit          stable, moved, ev, term;
    x = '0;
    if (reset) begin
      m_e = 0; m_hist.delete(); m_last = 16'h0;
      m_state = M_IDLE; m_reason = 0; m_prog = 0; m_elapsed = 0;
    end else begin
      m_e++;
      m_hist.push_back(v);
      // A code is accepted once it was seen on S consecutive edges, two edges of sync later.
      cand = sample(m_e - 2);
      stable = 1'b1;
      for (int k = 1; k < S; k++) if (sample(m_e - 2 - k) != cand) stable = 1'b0;
      ev = 1'b0; moved = 1'b0;
      term = (m_state >= M_PASSED);
      if (stable && cand != m_last) begin
        ev = 1'b1;
        m_last = cand;
        if (!term) begin
          if (cand == C_FAIL) begin
            m_state = M_FAILED; m_reason = 1; moved = 1'b1;
          end else if (cand == C_PASS) begin
            m_reason = (m_state == M_IDLE) ? 2 : 0;
            m_state  = (m_state == M_IDLE) ? M_FAILED : M_PASSED;
            moved = 1'b1;
          end else if (cand == C_START) begin
            m_reason = (m_state == M_IDLE) ? 0 : 2;
            m_state  = (m_state == M_IDLE) ? M_RUN : M_FAILED;
            moved = 1'b1;
          end else if (m_state == M_RUN) begin
            m_prog = (m_prog < (1 << PW) - 1) ? m_prog + 1 : m_prog;
          end
        end
      end
      if (!term && !moved && m_e == TO) begin
        m_state = M_TIMEOUT; m_reason = 3;
      end
      if (m_state < M_PASSED) m_elapsed = m_e;
      x.state   = 3'(m_state);
      x.reason  = 2'(m_reason);
      x.prog    = PW'(m_prog);
      x.code    = m_last;
      x.ev      = ev;
      x.elapsed = 20'(m_elapsed);
      x.done    = (m_state >= M_PASSED);
      x.pass    = (m_state == M_PASSED);
    end
    exp_q.push_back(x);
  endtask

  task automatic cycle(input bit r, input bit c, input logic [15:0] v);
    rst = r; clr = c; status = v;
    model_step(r || c, v);
    @(posedge clk); #2;
  endtask

  task automatic seg(input logic [15:0] v, input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, v);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 16'h0);
  endtask

  // Monitor: one predicted vector per edge, compared 1 time unit after the edge.
  initial begin
    obs_t e;
    forever begin
      @(posedge clk); #1;
      if (event_o === 1'b1) ev_seen++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("outputs", 64'(dut_obs), 64'(e));
      end
    end
  end

  initial begin
    int ev0, ncyc, cnt, len, k;
    logic [15:0] v, prev;
    @(posedge clk); #2;

    // Nominal pass
    do_reset(5);
    check("reset_all_zero", 64'(dut_obs), 64'd0);
    ev0 = ev_seen;
    seg(C_START, 5);
    check("t1_idle_before_latency", 64'(state_o), 64'd0);
    seg(C_START, 1);
    check("t1_running_after_5", 64'(state_o), 64'd1);
    seg(C_START, 4);
    seg(C_PASS, 8);
    check("t1_state", 64'(state_o), 64'd2);
    check("t1_pass", 64'(pass_o), 64'd1);
    check("t1_done", 64'(done_o), 64'd1);
    check("t1_last_code", 64'(last_code_o), 64'hAB00);
    check("t1_progress", 64'(progress_count_o), 64'd0);
    check("t1_event_count", 64'(ev_seen - ev0), 64'd2);

    // Glitch rejection and progress
    do_reset(2);
    seg(C_START, 6);
    ev0 = ev_seen;
    seg(C_PASS, 3);
    seg(C_START, 6);
    check("t2_glitch_no_event", 64'(ev_seen - ev0), 64'd0);
    check("t2_still_running", 64'(state_o), 64'd1);
    seg(16'hA012, 6);
    seg(16'hA034, 6);
    check("t2_progress", 64'(progress_count_o), 64'd2);

    // Ordering and fail code
    do_reset(2);
    seg(C_PASS, 7);
    check("t3_order_state", 64'(state_o), 64'd3);
    check("t3_order_reason", 64'(fail_reason_o), 64'd2);
    cycle(1'b0, 1'b1, 16'h0);
    check("t3_clear", 64'(dut_obs), 64'd0);
    seg(C_START, 6);
    seg(C_FAIL, 6);
    check("t3_fail_state", 64'(state_o), 64'd3);
    check("t3_fail_reason", 64'(fail_reason_o), 64'd1);
    seg(C_PASS, 6);
    check("t3_sticky_code", 64'(last_code_o), 64'hAB00);
    check("t3_sticky_state", 64'(state_o), 64'd3);

    // Timeout and collision
    do_reset(2);
    seg(C_START, 49);
    check("t4_running_at_49", 64'(state_o), 64'd1);
    seg(C_START, 1);
    check("t4_timeout_state", 64'(state_o), 64'd4);
    check("t4_timeout_reason", 64'(fail_reason_o), 64'd3);
    seg(C_START, 5);
    check("t4_elapsed_frozen", 64'(elapsed_o), 64'd49);
    do_reset(2);
    seg(C_START, 44);
    seg(C_PASS, 6);
    check("t4_collision_pass", 64'(state_o), 64'd2);
    check("t4_collision_elapsed", 64'(elapsed_o), 64'd49);

    // Reset mid-operation
    do_reset(2);
    seg(C_START, 6);
    seg(16'hA011, 6); seg(16'hA022, 6); seg(16'hA033, 6);
    check("t5_progress_3", 64'(progress_count_o), 64'd3);
    cycle(1'b1, 1'b0, C_START);
    check("t5_reset_zero", 64'(dut_obs), 64'd0);
    seg(C_START, 5);
    check("t5_not_yet", 64'(state_o), 64'd0);
    seg(C_START, 1);
    check("t5_reaccepted", 64'(state_o), 64'd1);

    // Progress saturation
    do_reset(2);
    seg(C_START, 6);
    seg(16'hA101, 6); seg(16'hA202, 6); seg(16'hA303, 6); seg(16'hA404, 6);
    check("t6_saturated", 64'(progress_count_o), 64'd3);
    check("t6_running", 64'(state_o), 64'd1);

    // Randomized sequences, checked cycle by cycle through the scoreboard
    for (int t = 0; t < 40; t++) begin
      do_reset(int'($urandom_range(1, 2)));
      ncyc = int'($urandom_range(20, 80));
      cnt = 0;
      prev = 16'h0;
      while (cnt < ncyc) begin
        if ($urandom_range(0, 15) == 0) begin
          k = int'($urandom_range(1, 3));
          cycle(k[0], k[1], 16'($urandom));
          cnt++;
        end else begin
          case ($urandom_range(0, 7))
            0: v = C_START;
            1: v = C_PASS;
            2: v = C_FAIL;
            3: v = 16'hA012;
            4: v = 16'hA034;
            5: v = 16'h0000;
            6: v = prev;
            default: v = 16'($urandom);
          endcase
          len = int'($urandom_range(1, 7));
          seg(v, len);
          prev = v;
          cnt += len;
        end
      end
    end

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
